recovery_phase_sequencer: RTL
=============================

Name: recovery_phase_sequencer

Overview:
- Sits directly downstream of the commit stage.
- Consumes its recovery request (exception/refetch trigger, refetch type, recovering lane, committed-op count) and the execution-stage branch-mispredict request.
- Owns the pipeline phase, walks the active list / rename logic through a multi-cycle flush, and returns the pipeline to the commit phase.
- Drives the phase and unable-to-start-recovery signals that the commit stage reads combinationally.

Parameters:
COMMIT_WIDTH, 2, ops examined/committed per cycle by commit stage
AL_ENTRY_NUM, 64, active list depth (power of two)
FLUSH_WIDTH, 2, active-list entries walked/flushed per cycle in RECOVER_0
DRAIN_CYCLES, 2, cycles spent in RECOVER_1 before resuming commit (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
commit_recovery_req  in  1  recovery trigger from commit stage (already gated by unable_to_start_recovery)
commit_refetch_type  in  3  refetch type from commit stage
commit_num  in  $clog2(COMMIT_WIDTH)+1  ops committed in the same cycle as the request
al_valid_count  in  $clog2(AL_ENTRY_NUM)+1  valid active-list entries this cycle
exec_mispred_req  in  1  branch mispredict from execution stage
exec_flush_count  in  $clog2(AL_ENTRY_NUM)+1  entries younger than the mispredicted branch
store_drain_busy  in  1  committed stores still draining; blocks new recovery
phase  out  2  0=COMMIT, 1=RECOVER_0, 2=RECOVER_1
unable_to_start_recovery  out  1  combinational: (phase!=COMMIT) | store_drain_busy
refetch_valid  out  1  one-cycle pulse, first RECOVER_0 cycle
refetch_type_out  out  3  latched refetch type (REFETCH_TYPE_BRANCH_TARGET for exec mispredict)
flush_valid  out  1  flush_num entries flushed this cycle
flush_num  out  $clog2(FLUSH_WIDTH)+1  entries flushed this cycle
recovery_done  out  1  one-cycle pulse, last RECOVER_1 cycle

Behaviour:
- Reset (rst low, asynchronous): phase=COMMIT; remaining=0; drain counter=0; all registered outputs 0.
- Accepting a request (COMMIT phase only):
  - Accepted request = commit_recovery_req & !unable_to_start_recovery.
  - Otherwise exec_mispred_req & !unable_to_start_recovery.
  - Commit request has priority; a simultaneous exec request is dropped (the commit-side flush already covers it).
- Flush total, computed at the accept edge:
  - Commit request: al_valid_count - commit_num.
  - Exec request: exec_flush_count.
  - Unsigned arithmetic. The subtraction never underflows by contract; the bench asserts this.
- Latching: refetch_type_out is latched at accept. Exec requests latch REFETCH_TYPE_BRANCH_TARGET. Next state is RECOVER_0.
- RECOVER_0:
  - First cycle: refetch_valid=1.
  - Each cycle: flush_num=min(remaining, FLUSH_WIDTH); flush_valid=(flush_num!=0); remaining -= flush_num.
  - When remaining<=FLUSH_WIDTH at cycle start, this is the last RECOVER_0 cycle. Next state is RECOVER_1 with drain counter=DRAIN_CYCLES.
  - remaining=0 at entry: exactly one RECOVER_0 cycle, flush_valid=0, flush_num=0.
- RECOVER_1:
  - Drain counter decrements each cycle.
  - In the cycle where the counter==1: recovery_done=1, and next state is COMMIT.
- All requests are ignored while phase!=COMMIT. The commit stage sees unable_to_start_recovery=1 and must not commit the recovering op.
- store_drain_busy high in COMMIT holds off acceptance (request ignored, not queued). The upstream re-presents the request each cycle.
- Latency: accept edge to first flush cycle = 1 cycle. Total recovery = ceil(total/FLUSH_WIDTH) (min 1) + DRAIN_CYCLES cycles.
- flush_num, flush_valid, refetch_valid and recovery_done are registered-state decodes. They are 0 outside their phase.
- Reset asserted mid-recovery: returns immediately to COMMIT with all outputs 0. No recovery_done pulse.

Test Plan:
- Reset: hold rst=0 -> phase=0, unable_to_start_recovery=store_drain_busy, all pulses 0. Release, idle 5 cycles -> no change.
- Commit recovery, al_valid_count=7, commit_num=2, refetch_type=3 -> refetch_valid pulse with type 3; flush_num 2,2,1 over 3 cycles; 2 RECOVER_1 cycles; recovery_done at cycle 5 after accept; phase back to 0.
- Simultaneous commit and exec requests (exec_flush_count=10, al_valid_count=4, commit_num=0) -> commit wins; flush_num 2,2; exec request never serviced.
- Exec mispredict with exec_flush_count=0 -> one RECOVER_0 cycle with flush_valid=0, refetch_type_out=BRANCH_TARGET; recovery_done 3 cycles after accept.
- store_drain_busy=1 with commit_recovery_req held 3 cycles, then busy drops -> unable=1 for those cycles, no phase change; accept on the first cycle busy=0.
- Assert rst mid-RECOVER_0 with remaining=20 -> phase=0 asynchronously, flush_valid=0, no recovery_done. A fresh request after release flushes a fresh total.

Source files
------------

// File: rtl/recovery_phase_sequencer.sv
// ---------------------------------------------------------------------------
// recovery_phase_sequencer
//
// Owns the pipeline phase after the commit stage. It accepts either a commit
// recovery request or an execution-stage branch mispredict while in COMMIT,
// walks the active list through a multi-cycle flush (RECOVER_0), waits a
// fixed number of drain cycles (RECOVER_1) and then returns to COMMIT.
//
// Ports
//   clk                       clock
//   rst                       asynchronous, active-low reset
//   commit_recovery_req       recovery trigger from commit stage
//   commit_refetch_type       refetch type from commit stage
//   commit_num                ops committed alongside the request
//   al_valid_count            valid active-list entries this cycle
//   exec_mispred_req          branch mispredict from execution stage
//   exec_flush_count          entries younger than the mispredicted branch
//   store_drain_busy          committed stores still draining
//   phase                     0=COMMIT, 1=RECOVER_0, 2=RECOVER_1
//   unable_to_start_recovery  (phase!=COMMIT) | store_drain_busy
//   refetch_valid             pulse on the first RECOVER_0 cycle
//   refetch_type_out          refetch type latched at accept
//   flush_valid               flush_num entries flushed this cycle
//   flush_num                 entries flushed this cycle
//   recovery_done             pulse on the last RECOVER_1 cycle
//
// Exec mispredicts report refetch type REFETCH_TYPE_BRANCH_TARGET (3'd1).
// ---------------------------------------------------------------------------
module recovery_phase_sequencer #(
    parameter int COMMIT_WIDTH = 2,
    parameter int AL_ENTRY_NUM = 64,
    parameter int FLUSH_WIDTH  = 2,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           commit_recovery_req,
    input  logic [2:0]                     commit_refetch_type,
    input  logic [$clog2(COMMIT_WIDTH):0]  commit_num,
    input  logic [$clog2(AL_ENTRY_NUM):0]  al_valid_count,
    input  logic                           exec_mispred_req,
    input  logic [$clog2(AL_ENTRY_NUM):0]  exec_flush_count,
    input  logic                           store_drain_busy,
    output logic [1:0]                     phase,
    output logic                           unable_to_start_recovery,
    output logic                           refetch_valid,
    output logic [2:0]                     refetch_type_out,
    output logic                           flush_valid,
    output logic [$clog2(FLUSH_WIDTH):0]   flush_num,
    output logic                           recovery_done
);

    localparam int AW  = $clog2(AL_ENTRY_NUM) + 1;
    localparam int FNW = $clog2(FLUSH_WIDTH) + 1;
    localparam int DW  = $clog2(DRAIN_CYCLES + 1);

    localparam logic [2:0]    REFETCH_TYPE_BRANCH_TARGET = 3'd1;
    localparam logic [AW-1:0] FLUSH_W_A  = AW'(FLUSH_WIDTH);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    typedef enum logic [1:0] {
        PH_COMMIT    = 2'd0,
        PH_RECOVER_0 = 2'd1,
        PH_RECOVER_1 = 2'd2
    } phase_e;

    phase_e          phase_q, phase_d;
    logic [AW-1:0]   remaining_q, remaining_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            first_q, first_d;
    logic [2:0]      refetch_type_q, refetch_type_d;

    logic            commit_accept;
    logic            exec_accept;
    logic [AW-1:0]   flush_amt;

    // Commit side wins; a simultaneous mispredict is younger than the
    // recovering op and is already covered by the commit-side flush.
    assign unable_to_start_recovery = (phase_q != PH_COMMIT) | store_drain_busy;
    assign commit_accept = commit_recovery_req & ~unable_to_start_recovery;
    assign exec_accept   = exec_mispred_req & ~commit_recovery_req & ~unable_to_start_recovery;

    // Entries flushed this cycle: min(remaining, FLUSH_WIDTH)
    assign flush_amt = (remaining_q > FLUSH_W_A) ? FLUSH_W_A : remaining_q;

    always_comb begin
        phase_d        = phase_q;
        remaining_d    = remaining_q;
        drain_d        = drain_q;
        first_d        = 1'b0;
        refetch_type_d = refetch_type_q;
        case (phase_q)
            PH_COMMIT: begin
                if (commit_accept) begin
                    phase_d        = PH_RECOVER_0;
                    remaining_d    = al_valid_count - AW'(commit_num);
                    refetch_type_d = commit_refetch_type;
                    first_d        = 1'b1;
                end else if (exec_accept) begin
                    phase_d        = PH_RECOVER_0;
                    remaining_d    = exec_flush_count;
                    refetch_type_d = REFETCH_TYPE_BRANCH_TARGET;
                    first_d        = 1'b1;
                end
            end
            PH_RECOVER_0: begin
                remaining_d = remaining_q - flush_amt;
                // Last walk cycle covers the zero-entry case as well.
                if (remaining_q <= FLUSH_W_A) begin
                    phase_d = PH_RECOVER_1;
                    drain_d = DRAIN_INIT;
                end
            end
            PH_RECOVER_1: begin
                drain_d = drain_q - DRAIN_ONE;
                if (drain_q == DRAIN_ONE) begin
                    phase_d = PH_COMMIT;
                end
            end
            default: begin
                phase_d     = PH_COMMIT;
                remaining_d = '0;
                drain_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q        <= PH_COMMIT;
            remaining_q    <= '0;
            drain_q        <= '0;
            first_q        <= 1'b0;
            refetch_type_q <= 3'd0;
        end else begin
            phase_q        <= phase_d;
            remaining_q    <= remaining_d;
            drain_q        <= drain_d;
            first_q        <= first_d;
            refetch_type_q <= refetch_type_d;
        end
    end

    // Output decodes of registered state only.
    always_comb begin
        phase            = phase_q;
        refetch_type_out = refetch_type_q;
        refetch_valid    = first_q;
        flush_num        = '0;
        flush_valid      = 1'b0;
        recovery_done    = 1'b0;
        if (phase_q == PH_RECOVER_0) begin
            flush_num   = FNW'(flush_amt);
            flush_valid = (flush_amt != '0);
        end
        if (phase_q == PH_RECOVER_1 && drain_q == DRAIN_ONE) begin
            recovery_done = 1'b1;
        end
    end

endmodule
